// File: rtl/timer_regs.sv
// Timer IP register bank: TCR/TDR/TCMP/TIER/TISR, prescaler, 64-bit counter and level interrupt.
// Read data and TCR write error are combinational within the access cycle.
module timer_regs #(
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned DIV_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [31:0]       reg_wdata,
   input  logic [3:0]        reg_wstrb,
   output logic [31:0]       reg_rdata,
   output logic              reg_error,
   output logic              tim_int
);

   logic [ADDR_W-3:0] word;
   logic sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_tier, sel_tisr;

   logic        timer_en_q, timer_en_d;
   logic        div_en_q, div_en_d;
   logic [3:0]  div_val_q, div_val_d;
   logic [7:0]  cnt_div_q, cnt_div_d;
   logic [63:0] cnt_q, cnt_d;
   logic [63:0] cmp_q, cmp_d;
   logic        int_en_q, int_en_d;
   logic        int_st_q, int_st_d;

   logic [7:0]  div_lim;
   logic        tick;
   logic        tcr_err;
   logic        w1c;
   logic [31:0] rd_mux;
   logic        unused_addr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
      end
      return res;
   endfunction

   assign unused_addr = ^reg_addr[1:0];
   assign word        = reg_addr[ADDR_W-1:2];
   assign sel_tcr     = (word == (ADDR_W-2)'(0));
   assign sel_tdr0    = (word == (ADDR_W-2)'(1));
   assign sel_tdr1    = (word == (ADDR_W-2)'(2));
   assign sel_tcmp0   = (word == (ADDR_W-2)'(3));
   assign sel_tcmp1   = (word == (ADDR_W-2)'(4));
   assign sel_tier    = (word == (ADDR_W-2)'(5));
   assign sel_tisr    = (word == (ADDR_W-2)'(6));

   assign tcr_err   = wr_en & sel_tcr & reg_wstrb[1] & ({28'd0, reg_wdata[11:8]} > DIV_MAX);
   assign reg_error = tcr_err & ~rst;

   assign div_lim = 8'((9'd1 << div_val_q) - 9'd1);
   assign tick    = timer_en_q & (~div_en_q | (cnt_div_q == div_lim));
   assign w1c     = wr_en & sel_tisr & reg_wstrb[0] & reg_wdata[0];
   assign tim_int = int_en_q & int_st_q & ~rst;

   always_comb begin
      rd_mux = 32'd0;
      if (sel_tcr)   rd_mux = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
      if (sel_tdr0)  rd_mux = cnt_q[31:0];
      if (sel_tdr1)  rd_mux = cnt_q[63:32];
      if (sel_tcmp0) rd_mux = cmp_q[31:0];
      if (sel_tcmp1) rd_mux = cmp_q[63:32];
      if (sel_tier)  rd_mux = {31'd0, int_en_q};
      if (sel_tisr)  rd_mux = {31'd0, int_st_q};
   end

   assign reg_rdata = (rd_en & ~wr_en & ~rst) ? rd_mux : 32'd0;

   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      div_val_d  = div_val_q;
      if (wr_en & sel_tcr & ~tcr_err) begin
         if (reg_wstrb[0]) begin
            timer_en_d = reg_wdata[0];
            div_en_d   = reg_wdata[1];
         end
         if (reg_wstrb[1]) div_val_d = reg_wdata[11:8];
      end

      if (!timer_en_q || !div_en_q) cnt_div_d = 8'd0;
      else if (cnt_div_q == div_lim) cnt_div_d = 8'd0;
      else cnt_div_d = cnt_div_q + 8'd1;

      // CPU write wins over a tick; unwritten lanes keep the pre-tick value
      cnt_d = tick ? cnt_q + 64'd1 : cnt_q;
      if (wr_en && (sel_tdr0 || sel_tdr1)) begin
         cnt_d = cnt_q;
         if (sel_tdr0) cnt_d[31:0]  = merge(cnt_q[31:0], reg_wdata, reg_wstrb);
         if (sel_tdr1) cnt_d[63:32] = merge(cnt_q[63:32], reg_wdata, reg_wstrb);
      end

      cmp_d = cmp_q;
      if (wr_en && sel_tcmp0) cmp_d[31:0]  = merge(cmp_q[31:0], reg_wdata, reg_wstrb);
      if (wr_en && sel_tcmp1) cmp_d[63:32] = merge(cmp_q[63:32], reg_wdata, reg_wstrb);

      int_en_d = int_en_q;
      if (wr_en && sel_tier && reg_wstrb[0]) int_en_d = reg_wdata[0];

      int_st_d = (cnt_q == cmp_q) | (int_st_q & ~w1c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_en_q <= 1'b0;
         div_en_q   <= 1'b0;
         div_val_q  <= 4'd1;
         cnt_div_q  <= 8'd0;
         cnt_q      <= 64'd0;
         cmp_q      <= {64{1'b1}};
         int_en_q   <= 1'b0;
         int_st_q   <= 1'b0;
      end else begin
         timer_en_q <= timer_en_d;
         div_en_q   <= div_en_d;
         div_val_q  <= div_val_d;
         cnt_div_q  <= cnt_div_d;
         cnt_q      <= cnt_d;
         cmp_q      <= cmp_d;
         int_en_q   <= int_en_d;
         int_st_q   <= int_st_d;
      end
   end

endmodule

// File: tb/tb_timer_regs.sv
// Directed bench for timer_regs: expectations queued at drive time, popped and checked
// against DUT outputs at the falling edge of the access cycle.
module tb_timer_regs;

   localparam logic [12:0] A_TCR   = 13'h000;
   localparam logic [12:0] A_TDR0  = 13'h004;
   localparam logic [12:0] A_TDR1  = 13'h008;
   localparam logic [12:0] A_TCMP0 = 13'h00C;
   localparam logic [12:0] A_TCMP1 = 13'h010;
   localparam logic [12:0] A_TIER  = 13'h014;
   localparam logic [12:0] A_TISR  = 13'h018;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [12:0] reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [3:0]  reg_wstrb = '0;
   logic [31:0] reg_rdata;
   logic        reg_error;
   logic        tim_int;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sbq[$];
   int  n_cmp = 0;
   int  n_mis = 0;

   timer_regs #(.ADDR_W(13), .DIV_MAX(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wstrb (reg_wstrb),
      .reg_rdata (reg_rdata),
      .reg_error (reg_error),
      .tim_int   (tim_int)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      sb_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_mis++;
         $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push_exp(tag, exp);
      pop_cmp(obs);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_rdata", {31'd0, reg_error} | reg_rdata, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [12:0] a, input logic [31:0] exp);
      @(posedge clk);
      #1;
      rd_en    = 1'b1;
      reg_addr = a;
      push_exp(tag, exp);
      @(negedge clk);
      pop_cmp(reg_rdata);
      @(posedge clk);
      #1 rd_en = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [12:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic exp_err);
      @(posedge clk);
      #1;
      wr_en     = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      reg_wstrb = s;
      push_exp(tag, {31'd0, exp_err});
      @(negedge clk);
      pop_cmp({31'd0, reg_error});
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   initial begin
      // 1: reset values
      idle(2);
      rst = 1'b0;
      do_reset();
      rd("rst_tcr",   A_TCR,   32'h0000_0100);
      rd("rst_tdr0",  A_TDR0,  32'h0);
      rd("rst_tdr1",  A_TDR1,  32'h0);
      rd("rst_tcmp0", A_TCMP0, 32'hFFFF_FFFF);
      rd("rst_tcmp1", A_TCMP1, 32'hFFFF_FFFF);
      rd("rst_tier",  A_TIER,  32'h0);
      rd("rst_tisr",  A_TISR,  32'h0);
      chk("rst_tim_int", {31'd0, tim_int}, 32'd0);
      rd("unmapped_01c", 13'h01C, 32'h0);
      rd("unmapped_100", 13'h100, 32'h0);
      wr("unmapped_wr_err", 13'h040, 32'hFFFF_FFFF, 4'hF, 1'b0);

      // 2: undivided count, 10 ticks between enable edge and disable edge
      wr("tcr_en_err", A_TCR, 32'h1, 4'hF, 1'b0);
      idle(8);
      wr("tcr_off_err", A_TCR, 32'h0, 4'hF, 1'b0);
      rd("run10_tdr0", A_TDR0, 32'd10);
      rd("run10_tdr1", A_TDR1, 32'd0);

      // 3: divide by 4 over 40 cycles
      wr("tdr0_clr_err", A_TDR0, 32'h0, 4'hF, 1'b0);
      wr("tcr_div_err", A_TCR, 32'h0000_0203, 4'hF, 1'b0);
      idle(39);
      wr("tcr_off2_err", A_TCR, 32'h0, 4'hF, 1'b0);
      rd("div4_tdr0", A_TDR0, 32'd10);
      rd("tcr_zero", A_TCR, 32'h0);

      // 4: illegal div_val drops the whole TCR write
      do_reset();
      wr("tcr_illegal_err", A_TCR, 32'h0000_0901, 4'hF, 1'b1);
      rd("tcr_after_illegal", A_TCR, 32'h0000_0100);
      idle(3);
      rd("tdr0_after_illegal", A_TDR0, 32'h0);
      wr("tcr_divmax_err", A_TCR, 32'h0000_0800, 4'h2, 1'b0);
      rd("tcr_divmax", A_TCR, 32'h0000_0800);
      wr("tcr_lane0_only_err", A_TCR, 32'h0000_0F02, 4'h1, 1'b0);
      rd("tcr_lane0_only", A_TCR, 32'h0000_0802);

      // reset during an illegal write: error suppressed, registers at reset value
      @(posedge clk);
      #1;
      rst = 1'b1; wr_en = 1'b1; reg_addr = A_TCR; reg_wdata = 32'h0000_0901; reg_wstrb = 4'hF;
      @(negedge clk);
      chk("rst_mid_err", {31'd0, reg_error}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0; wr_en = 1'b0;
      rd("rst_mid_tcr", A_TCR, 32'h0000_0100);

      // 5: low-to-high carry and compare interrupt
      wr("tdr0_set_err", A_TDR0, 32'hFFFF_FFFE, 4'hF, 1'b0);
      wr("tdr1_set_err", A_TDR1, 32'h0, 4'hF, 1'b0);
      wr("tcmp0_set_err", A_TCMP0, 32'h0, 4'hF, 1'b0);
      wr("tcmp1_set_err", A_TCMP1, 32'h1, 4'hF, 1'b0);
      wr("tier_set_err", A_TIER, 32'h1, 4'hF, 1'b0);
      chk("int_before_run", {31'd0, tim_int}, 32'd0);
      wr("tcr_run_err", A_TCR, 32'h1, 4'hF, 1'b0);
      wr("tcr_stop_err", A_TCR, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      chk("int_match_cycle", {31'd0, tim_int}, 32'd0);
      @(negedge clk);
      chk("int_after_match", {31'd0, tim_int}, 32'd1);
      rd("carry_tdr1", A_TDR1, 32'h1);
      rd("carry_tdr0", A_TDR0, 32'h0);
      wr("w1c_match_err", A_TISR, 32'h1, 4'h1, 1'b0);
      rd("tisr_held", A_TISR, 32'h1);
      chk("int_held", {31'd0, tim_int}, 32'd1);
      wr("tcmp0_move_err", A_TCMP0, 32'h5, 4'hF, 1'b0);
      wr("w1c_clear_err", A_TISR, 32'h1, 4'h1, 1'b0);
      rd("tisr_cleared", A_TISR, 32'h0);
      chk("int_cleared", {31'd0, tim_int}, 32'd0);

      // 6: partial-lane compare writes
      do_reset();
      wr("tcmp0_lane_err", A_TCMP0, 32'hAABB_CCDD, 4'b0001, 1'b0);
      rd("tcmp0_lane", A_TCMP0, 32'hFFFF_FFDD);
      wr("tcmp1_lane_err", A_TCMP1, 32'hAABB_CCDD, 4'b0110, 1'b0);
      rd("tcmp1_lane", A_TCMP1, 32'hFFBB_CCFF);

      // full 64-bit wrap: two ticks from all-ones
      wr("wrap_tdr0_err", A_TDR0, 32'hFFFF_FFFF, 4'hF, 1'b0);
      wr("wrap_tdr1_err", A_TDR1, 32'hFFFF_FFFF, 4'hF, 1'b0);
      wr("wrap_run_err", A_TCR, 32'h1, 4'hF, 1'b0);
      wr("wrap_stop_err", A_TCR, 32'h0, 4'hF, 1'b0);
      rd("wrap_tdr0", A_TDR0, 32'h1);
      rd("wrap_tdr1", A_TDR1, 32'h0);

      // simultaneous rd_en/wr_en: write lands, read data forced to zero
      @(posedge clk);
      #1;
      wr_en = 1'b1; rd_en = 1'b1; reg_addr = A_TIER; reg_wdata = 32'h1; reg_wstrb = 4'hF;
      @(negedge clk);
      chk("both_rdata", reg_rdata, 32'h0);
      @(posedge clk);
      #1 wr_en = 1'b0; rd_en = 1'b0;
      rd("both_tier", A_TIER, 32'h1);

      chk("sb_drained", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
